// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: op codes, legality
// limit and arbiter state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ZERO  = 4'h0;
    localparam logic [3:0] ALU_ADD   = 4'h1;
    localparam logic [3:0] ALU_SUB   = 4'h2;
    localparam logic [3:0] ALU_PASSB = 4'h3;
    localparam logic [3:0] ALU_SLT   = 4'h4;
    localparam logic [3:0] ALU_SLTU  = 4'h5;
    localparam logic [3:0] ALU_XOR   = 4'h6;
    localparam logic [3:0] ALU_OR    = 4'h7;
    localparam logic [3:0] ALU_AND   = 4'h8;
    localparam logic [3:0] ALU_SLL   = 4'h9;
    localparam logic [3:0] ALU_SRL   = 4'hA;
    localparam logic [3:0] ALU_SRA   = 4'hB;

    localparam logic [3:0] ALU_CTRL_MAX = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic ctrl_illegal(input logic [3:0] ctrl);
        return ctrl > ALU_CTRL_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// RV32I ALU: combinational result and zero flag; codes above ALU_CTRL_MAX
// produce 0.
module alu #(
    parameter int size = 32
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [size-1:0] y,
    output logic            zero
);
    import alu_pkg::*;

    always_comb begin
        y = '0;
        case (ctrl)
            ALU_ZERO:  y = '0;
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_PASSB: y = b;
            ALU_SLT:   y = {{(size-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  y = {{(size-1){1'b0}}, (a < b)};
            ALU_XOR:   y = a ^ b;
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_SLL:   y = a << b[4:0];
            ALU_SRL:   y = a >> b[4:0];
            ALU_SRA:   y = $signed(a) >>> b[4:0];
            default:   y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_arb_grant.sv
// Two-port grant logic. With ALU_ARB_RR_EN defined it round-robins on
// contention and owns the last_grant pointer; otherwise port 0 always wins.
module alu_arb_grant (
`ifdef ALU_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic valid0,
    input  logic valid1,
    input  logic en,
    output logic grant0,
    output logic grant1
);
`ifdef ALU_ARB_RR_EN
    logic last_grant;
    logic pick1;

    assign pick1  = valid1 & (~valid0 | ~last_grant);
    assign grant0 = en & valid0 & ~pick1;
    assign grant1 = en & pick1;

    // Reset as though port 1 was served last, so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (grant0 | grant1)
            last_grant <= grant1;
    end
`else
    assign grant0 = en & valid0;
    assign grant1 = en & valid1 & ~valid0;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the trap/CSR unit
// (port 1). Arbitration mode selected by ALU_ARB_RR_EN (round-robin when defined).
//
// state | meaning
// IDLE  | no op held; grant one requester
// EXEC  | operands latched; ALU evaluates, result registered
// RESP  | result held until rsp_ready
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_id,
    output logic             rsp_err
);
    import alu_pkg::*;

    arb_state_t       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic             id_q;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             grant0;
    logic             grant1;
    logic             arb_en;

    // Gated by rst so no request is granted while reset is held.
    assign arb_en = (state == IDLE) & ~rst;

    alu_arb_grant u_grant (
`ifdef ALU_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .en     (arb_en),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    alu #(.size(WIDTH)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .ctrl (ctrl_q),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        a_q    <= grant1 ? req1_a : req0_a;
                        b_q    <= grant1 ? req1_b : req0_b;
                        ctrl_q <= grant1 ? req1_ctrl : req0_ctrl;
                        id_q   <= grant1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_y;
                    rsp_zero  <= alu_zero;
                    rsp_id    <= id_q;
                    rsp_err   <= ctrl_illegal(ctrl_q);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases then randomized ops,
// checked against a behavioural model of ALU results and arbitration order.
module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_id, rsp_err;
    logic [31:0] rsp_data;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    bit exp_last = 1'b1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    function automatic logic [31:0] ref_y(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        int signed   sa = a;
        int signed   sb = b;
        int unsigned sh = b % 32;
        case (c)
            4'd0:    return 32'd0;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return b;
            4'd4:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd5:    return (a < b) ? 32'd1 : 32'd0;
            4'd6:    return a ^ b;
            4'd7:    return a | b;
            4'd8:    return a & b;
            4'd9:    return a << sh;
            4'd10:   return a >> sh;
            4'd11:   return sa >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input bit v0, input bit v1, input int bp);
        logic [1:0]  gnt;
        logic [3:0]  c;
        logic [31:0] ey;
        bit          port;
        int          waited = 0;
        req0_valid = v0;
        req1_valid = v1;
        rsp_ready  = (bp == 0);
        gnt = 2'b00;
        while (gnt == 2'b00 && waited < 10) begin
            @(negedge clk);
            gnt = {req1_ready, req0_ready};
            waited++;
        end
        if (gnt == 2'b00) begin
            chk("grant_timeout", 32'd0, 32'd1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            rsp_ready  = 1'b1;
            return;
        end
        if (v0 && v1) port = (RR && !exp_last);
        else          port = v1;
        chk("grant", gnt, port ? 2'b10 : 2'b01);
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        c  = port ? req1_ctrl : req0_ctrl;
        ey = port ? ref_y(c, req1_a, req1_b) : ref_y(c, req0_a, req0_b);
        @(posedge clk);
        #1;
        exp_last = port;
        if (gnt[0]) req0_valid = 1'b0;
        if (gnt[1]) req1_valid = 1'b0;
        @(negedge clk);
        chk("exec_rsp_valid", rsp_valid, 1'b0);
        chk("exec_ready", {req1_ready, req0_ready}, 2'b00);
        for (int i = 0; i <= bp; i++) begin
            @(negedge clk);
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_data", rsp_data, ey);
            chk("rsp_zero", rsp_zero, (ey == 32'd0));
            chk("rsp_id", rsp_id, port);
            chk("rsp_err", rsp_err, (c > 4'd11));
            chk("resp_ready", {req1_ready, req0_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        if (req0_valid || req1_valid) run_op(req0_valid, req1_valid, 0);
    endtask

    task automatic reset_mid(input bit in_resp);
        req0_a     = 32'h1234_0000;
        req0_b     = 32'h0000_5678;
        req0_ctrl  = 4'd7;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        chk("rm_ready0", req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        exp_last   = 1'b0;
        if (in_resp) begin
            @(negedge clk);
            @(negedge clk);
            chk("rm_in_resp", rsp_valid, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_last = 1'b1;
        @(negedge clk);
        chk("rm_rsp_valid", rsp_valid, 1'b0);
        chk("rm_rsp_data", rsp_data, 32'd0);
        chk("rm_rsp_zero", rsp_zero, 1'b0);
        chk("rm_rsp_id", rsp_id, 1'b0);
        chk("rm_rsp_err", rsp_err, 1'b0);
        chk("rm_ready", {req1_ready, req0_ready}, 2'b00);
        rsp_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags", {rsp_zero, rsp_id, rsp_err}, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_ctrl = 4'd1;
        run_op(1, 0, 0);
        req1_a = 32'd5; req1_b = 32'd5; req1_ctrl = 4'd2;
        run_op(0, 1, 0);
        req1_a = 32'hFFFF_FFFB; req1_b = 32'd3; req1_ctrl = 4'd4;
        run_op(0, 1, 0);
        req1_ctrl = 4'd5;
        run_op(0, 1, 0);
        req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF; req1_ctrl = 4'b1110;
        run_op(0, 1, 0);

        req0_a = 32'h8000_0000; req0_b = 32'h24; req0_ctrl = 4'd11;
        req1_a = $urandom; req1_b = $urandom; req1_ctrl = 4'd6;
        run_op(1, 1, 5);
        drain();

        for (int k = 0; k < 4; k++) begin
            if (!req0_valid) begin
                req0_a = rand_word(); req0_b = rand_word(); req0_ctrl = $urandom_range(0, 11);
            end
            if (!req1_valid) begin
                req1_a = rand_word(); req1_b = rand_word(); req1_ctrl = $urandom_range(0, 11);
            end
            run_op(1, 1, 0);
        end
        drain();

        reset_mid(1'b0);
        req1_a = 32'd9; req1_b = 32'd2; req1_ctrl = 4'd9;
        run_op(1, 1, 0);
        drain();
        reset_mid(1'b1);
        req1_a = 32'd9; req1_b = 32'd2; req1_ctrl = 4'd10;
        run_op(1, 1, 0);
        drain();

        for (int k = 0; k < 24; k++) begin
            bit n0, n1;
            if (!req0_valid) begin
                req0_a = rand_word(); req0_b = rand_word(); req0_ctrl = $urandom_range(0, 15);
            end
            if (!req1_valid) begin
                req1_a = rand_word(); req1_b = rand_word(); req1_ctrl = $urandom_range(0, 15);
            end
            n0 = req0_valid | 1'($urandom_range(0, 1));
            n1 = req1_valid | 1'($urandom_range(0, 1));
            if (!n0 && !n1) n0 = 1'b1;
            run_op(n0, n1, $urandom_range(0, 3));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
